// File: rtl/load_scoreboard_pkg.sv
// Shared pipeline definitions for the decode-stage load scoreboard.
// Holds the register file geometry and the default scoreboard capacity.
package load_scoreboard_pkg;

    localparam int REG_LENGTH          = 5;
    localparam int NUM_REGS            = 32;
    localparam int CNT_WIDTH_DEF       = 2;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef logic [REG_LENGTH-1:0] reg_idx_t;

endpackage : load_scoreboard_pkg

// File: rtl/load_scoreboard_if.sv
// Decode/execute/memory-return signals seen by the load scoreboard.
// The pipeline control (master) drives issue/flush/return and reads back the stall.
interface load_scoreboard_if;
    import load_scoreboard_pkg::*;

    logic     issue_valid;
    logic     issue_is_load;
    reg_idx_t issue_rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     flush_e;
    logic     ret_valid;
    reg_idx_t ret_rd;
    logic     stall_ld;
    logic     busy;
    logic     err_underflow;

    modport master (
        output issue_valid, issue_is_load, issue_rd, rs1, rs2, flush_e, ret_valid, ret_rd,
        input  stall_ld, busy, err_underflow
    );

    modport slave (
        input  issue_valid, issue_is_load, issue_rd, rs1, rs2, flush_e, ret_valid, ret_rd,
        output stall_ld, busy, err_underflow
    );

endinterface : load_scoreboard_if

// File: rtl/load_scoreboard.sv
// Counts loads in flight per destination register and stalls decode on a
// dependent source read that the fixed-latency forwarding path cannot cover.
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input logic              clk,
    input logic              rst_n,
    load_scoreboard_if.slave sb
);

    localparam int                   TOT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_next;
    logic [NUM_REGS-1:0]                reg_under;
    logic [TOT_W-1:0]                   total;
    logic [TOT_W-1:0]                   total_next;
    logic                               tot_under;
    logic                               ex_load_valid;
    reg_idx_t                           ex_load_rd;
    logic                               err_q;

    logic hazard1, hazard2, sat, full, stall;
    logic record, retire, unwind;

    function automatic logic [CNT_WIDTH-1:0] clamp_cnt(input logic [CNT_WIDTH:0] v);
        return (v > {1'b0, CNT_MAX}) ? CNT_MAX : v[CNT_WIDTH-1:0];
    endfunction

    // NOTE: every variable is given a value before any condition, so no latch is inferred.
    always_comb begin
        hazard1 = (sb.rs1 != '0) && (cnt[sb.rs1] != '0)
                  && !(sb.ret_valid && (sb.ret_rd == sb.rs1) && (cnt[sb.rs1] == CNT_ONE));
        hazard2 = (sb.rs2 != '0) && (cnt[sb.rs2] != '0)
                  && !(sb.ret_valid && (sb.ret_rd == sb.rs2) && (cnt[sb.rs2] == CNT_ONE));
        sat     = sb.issue_valid && sb.issue_is_load && (cnt[sb.issue_rd] == CNT_MAX);
        full    = sb.issue_valid && sb.issue_is_load
                  && (total == TOT_W'(MAX_OUTSTANDING)) && !sb.ret_valid;
        stall   = hazard1 || hazard2 || sat || full;

        record  = sb.issue_valid && sb.issue_is_load && !stall && !sb.flush_e
                  && (sb.issue_rd != '0);
        retire  = sb.ret_valid && (sb.ret_rd != '0);
        // ex_load_rd is never 0: only non-zero destinations are recorded
        unwind  = sb.flush_e && ex_load_valid;
    end

    // One increment and up to two decrements may hit the same register per cycle
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign cnt_next[r]  = '0;
            assign reg_under[r] = 1'b0;
        end else begin : g_track
            logic               inc;
            logic [1:0]         dec;
            logic [CNT_WIDTH:0] up;

            assign inc = record && (sb.issue_rd == reg_idx_t'(r));
            assign dec = 2'(retire && (sb.ret_rd == reg_idx_t'(r)))
                       + 2'(unwind && (ex_load_rd == reg_idx_t'(r)));
            assign up  = {1'b0, cnt[r]} + (CNT_WIDTH+1)'(inc);

            assign reg_under[r] = up < (CNT_WIDTH+1)'(dec);
            assign cnt_next[r]  = reg_under[r] ? '0 : clamp_cnt(up - (CNT_WIDTH+1)'(dec));
        end
    end

    always_comb begin
        logic [TOT_W:0] tot_up;
        logic [1:0]     tot_dec;
        tot_up     = {1'b0, total} + (TOT_W+1)'(record);
        tot_dec    = 2'(retire) + 2'(unwind);
        tot_under  = tot_up < (TOT_W+1)'(tot_dec);
        total_next = tot_under ? '0 : TOT_W'(tot_up - (TOT_W+1)'(tot_dec));
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset, unlike a RAM, since a stale count would stall decode forever.
            cnt           <= '0;
            total         <= '0;
            ex_load_valid <= 1'b0;
            ex_load_rd    <= '0;
            err_q         <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            total         <= total_next;
            ex_load_valid <= record;
            if (record) begin
                ex_load_rd <= sb.issue_rd;
            end
            err_q         <= err_q || (|reg_under) || tot_under;
        end
    end

    assign sb.stall_ld      = stall;
    assign sb.busy          = (total != '0);
    assign sb.err_underflow = err_q;

endmodule : load_scoreboard

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks register destinations of loads in flight to a variable-latency data memory. Produces the decode-stage stall that fixed-latency forwarding cannot cover. Sits beside the forwarding/hazard logic in decode: loads are recorded at issue, retired on memory return, and unwound when execute is flushed. It is the producer of load-hazard state that the forwarding path consumes.

## Interface
- REG_LENGTH, 5, register index width
- NUM_REGS, 32, architectural registers tracked
- CNT_WIDTH, 2, per-register outstanding-load counter width (max 3 per register)
- MAX_OUTSTANDING, 4, total loads in flight before issue is blocked
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode instruction advances to execute this cycle
- issue_is_load  in  1  advancing instruction is a load
- issue_rd  in  REG_LENGTH  its destination register
- rs1, rs2  in  REG_LENGTH  decode-stage source registers
- flush_e  in  1  instruction entering execute is squashed (same-cycle as issue) or instruction in execute squashed
- ret_valid  in  1  load data returned this cycle (written to regfile same cycle)
- ret_rd  in  REG_LENGTH  destination of returned load
- stall_ld  out  1  decode must hold (combinational)
- busy  out  1  any load outstanding (registered-state derived)
- err_underflow  out  1  sticky: return or unwind hit a zero counter

## Operation
- State: cnt[NUM_REGS] of CNT_WIDTH bits, total counter of clog2(MAX_OUTSTANDING+1) bits, ex_load_valid, ex_load_rd (shadow of the load currently in execute).
- Register 0 is never tracked. Issue, return, and unwind to rd 0 are ignored.
- Record: issue_valid & issue_is_load & ~stall_ld & ~flush_e & rd≠0 → cnt[rd]+1, total+1, ex_load_valid←1, ex_load_rd←rd. Otherwise ex_load_valid←0.
- Retire: ret_valid & ret_rd≠0 → cnt[ret_rd]−1, total−1.
- Unwind: flush_e & ex_load_valid → cnt[ex_load_rd]−1, total−1. The squashed load never returns.
- Net update per register = increments minus decrements from all three sources in the same cycle. Up to one increment and two decrements apply to one register (e.g. issue and return to the same rd → unchanged).
- Decrement at zero: the counter stays 0, err_underflow is set, and it clears only on reset.
- stall_ld = hazard1 | hazard2 | sat | full, where:
  - hazardN = rsN≠0 & cnt[rsN]≠0 & ~(ret_valid & ret_rd==rsN & cnt[rsN]==1). A last-pending return bypasses through the regfile write-first.
  - sat = issue_valid & issue_is_load & cnt[issue_rd]==max.
  - full = issue_valid & issue_is_load & total==MAX_OUTSTANDING & ~ret_valid.
- busy = total≠0.

## Timing
- Reset (async assert, sync-released by the system): all cnt 0, total 0, ex_load_valid 0, err_underflow 0. stall_ld then evaluates to 0, and busy 0.
- stall_ld is combinational from inputs and current state, with zero-cycle latency. All state updates on the rising clk edge.
- A load recorded at edge N stalls a dependent decode in cycle N+1 onward until the cycle its return arrives (no stall in that return cycle).
- Reset mid-operation discards all pending state. Returns arriving after reset raise err_underflow.
- Flush in the same cycle as a return for ex_load_rd: both decrements apply.

## Structure
- Shared pipeline package: REG_LENGTH, NUM_REGS, reg_idx_t typedef, and the MAX_OUTSTANDING default.
- Single module. No sub-module is needed. Counter update is a per-register generate loop with a common saturating up/down expression.

## Test plan
- Reset: rst_n low mid-cycle → stall_ld 0, busy 0, err_underflow 0 immediately.
- Load to x5 issued, then rs1=5 in decode → stall_ld 1 each cycle until ret_valid/ret_rd=5, where stall_ld 0 the same cycle. busy 0 next cycle.
- Load to x0 issued, then rs2=0 → no stall, cnt unchanged, busy stays 0.
- Four loads to x1..x4 outstanding, fifth load issuing → stall_ld 1. Same cycle with ret_valid → stall_ld 0 and the fifth load records.
- Load x7 issued, next cycle flush_e → cnt[7] returns to 0, rs1=7 no stall. A later stray ret_rd=7 sets err_underflow.
- Issue load x9 while ret_rd=9 returns with cnt[9]=1 → cnt[9] stays 1, total unchanged, dependent rs1=9 stalls next cycle.
